// File: rtl/cail_param_loader_pkg.sv
// Shared definitions for the calibration parameter loader: FSM encoding,
// index widths and EEPROM record geometry.
package cail_pkg;

    localparam int unsigned EEPROM_BYTES_PER_PARAM = 4;
    localparam logic [7:0]  DEFAULT_DEVICE_ID      = 8'hA0;
    localparam int unsigned CH_W                   = 4;
    localparam int unsigned TYPE_W                 = 2;
    localparam int unsigned CNT_W                  = $clog2(EEPROM_BYTES_PER_PARAM + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_COLLECT,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/cail_param_loader_if.sv
// Loader-side bus: iic_ctrl read port plus the parameter store write port.
interface cail_param_loader_if;
    import cail_pkg::*;

    logic              iic_r_req;
    logic [7:0]        iic_device_id;
    logic [15:0]       iic_reg_addr;
    logic              iic_addr_mode;
    logic [5:0]        iic_r_num;
    logic              iic_r_valid;
    logic [7:0]        iic_rd_data;
    logic              iic_wr_done;
    logic              iic_ack;
    logic              param_wr_req;
    logic [CH_W-1:0]   param_ch;
    logic [TYPE_W-1:0] param_type;
    logic [31:0]       param_data;

    modport master (
        output iic_r_req, iic_device_id, iic_reg_addr, iic_addr_mode, iic_r_num,
        input  iic_r_valid, iic_rd_data, iic_wr_done, iic_ack,
        output param_wr_req, param_ch, param_type, param_data
    );

    modport slave (
        input  iic_r_req, iic_device_id, iic_reg_addr, iic_addr_mode, iic_r_num,
        output iic_r_valid, iic_rd_data, iic_wr_done, iic_ack,
        input  param_wr_req, param_ch, param_type, param_data
    );

endinterface

// File: rtl/cail_param_loader_byte_assembler.sv
// Byte counter plus MSB-first shift register; exposes the post-edge word and
// fullness so the caller can act on a byte arriving in the same cycle.
module cail_byte_assembler
    import cail_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  data,
    output logic [31:0] word_nxt,
    output logic        full_nxt
);

    logic [31:0]      word;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;

    always_comb begin
        word_nxt  = word;
        count_nxt = count;
        if (clear) begin
            word_nxt  = '0;
            count_nxt = '0;
        end else if (shift && (count < CNT_W'(EEPROM_BYTES_PER_PARAM))) begin
            word_nxt  = {word[23:0], data};
            count_nxt = count + CNT_W'(1);
        end
    end

    assign full_nxt = (count_nxt == CNT_W'(EEPROM_BYTES_PER_PARAM));

    always_ff @(posedge clk) begin
        if (rst) begin
            word  <= '0;
            count <= '0;
        end else begin
            word  <= word_nxt;
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/cail_param_loader.sv
// Boot-time loader: reads each (channel, type) calibration word from the I2C
// EEPROM and writes it into the parameter store, type index innermost.
module cail_param_loader
    import cail_pkg::*;
#(
    parameter int unsigned NUM_CH    = 16,
    parameter int unsigned NUM_TYPE  = 3,
    parameter logic [7:0]  DEVICE_ID = DEFAULT_DEVICE_ID,
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [23:0] TIMEOUT   = 24'd5000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CH_W-1:0]   err_ch,
    output logic [TYPE_W-1:0] err_type,
    cail_param_loader_if.master bus
);

    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);
    localparam logic [TYPE_W-1:0] TYPE_LAST = TYPE_W'(NUM_TYPE - 1);
    // The counter holds 0 in the first COLLECT cycle, so ERR is entered the
    // cycle after it would step to TIMEOUT-1: TIMEOUT cycles after iic_r_req.
    localparam logic [23:0]       TMO_LAST  = TIMEOUT - 24'd2;

    state_t            state;
    state_t            state_next;
    logic [CH_W-1:0]   ch;
    logic [TYPE_W-1:0] typ;
    logic [23:0]       tmo_cnt;
    logic [31:0]       word_nxt;
    logic              full_nxt;
    logic              last_entry;

    assign bus.iic_device_id = DEVICE_ID;
    assign bus.iic_addr_mode = 1'b1;
    assign bus.iic_r_num     = 6'd4;
    assign last_entry        = (typ == TYPE_LAST) && (ch == CH_LAST);

    cail_byte_assembler u_asm (
        .clk      (clk),
        .rst      (rst),
        .clear    (state == ST_REQ),
        .shift    ((state == ST_COLLECT) && bus.iic_r_valid),
        .data     (bus.iic_rd_data),
        .word_nxt (word_nxt),
        .full_nxt (full_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (start) state_next = ST_REQ;
            ST_REQ:     state_next = ST_COLLECT;
            ST_COLLECT: begin
                if (bus.iic_wr_done)        state_next = (bus.iic_ack && full_nxt) ? ST_WRITE : ST_ERR;
                else if (tmo_cnt == TMO_LAST) state_next = ST_ERR;
            end
            ST_WRITE:   state_next = last_entry ? ST_DONE : ST_REQ;
            ST_DONE:    state_next = ST_IDLE;
            ST_ERR:     state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
            err_ch           <= '0;
            err_type         <= '0;
            ch               <= '0;
            typ              <= '0;
            tmo_cnt          <= '0;
            bus.iic_r_req    <= 1'b0;
            bus.iic_reg_addr <= '0;
            bus.param_wr_req <= 1'b0;
            bus.param_ch     <= '0;
            bus.param_type   <= '0;
            bus.param_data   <= '0;
        end else begin
            bus.iic_r_req    <= (state_next == ST_REQ);
            bus.param_wr_req <= (state_next == ST_WRITE);
            done             <= (state_next == ST_DONE);
            busy             <= state_next inside {ST_REQ, ST_COLLECT, ST_WRITE, ST_ERR};
            tmo_cnt          <= (state == ST_COLLECT) ? tmo_cnt + 24'd1 : '0;

            if ((state == ST_IDLE) && start) begin
                ch               <= '0;
                typ              <= '0;
                error            <= 1'b0;
                err_ch           <= '0;
                err_type         <= '0;
                bus.iic_reg_addr <= BASE_ADDR;
            end

            // Running address equals BASE_ADDR + 4*(ch*NUM_TYPE + type), wrapping at 2^16.
            if ((state == ST_WRITE) && (state_next == ST_REQ)) begin
                bus.iic_reg_addr <= bus.iic_reg_addr + 16'd4;
                if (typ == TYPE_LAST) begin
                    typ <= '0;
                    ch  <= ch + CH_W'(1);
                end else begin
                    typ <= typ + TYPE_W'(1);
                end
            end

            if (state_next == ST_WRITE) begin
                bus.param_ch   <= ch;
                bus.param_type <= typ;
                bus.param_data <= word_nxt;
            end

            if (state_next == ST_ERR) begin
                error    <= 1'b1;
                err_ch   <= ch;
                err_type <= typ;
            end
        end
    end

endmodule

// File: tb/tb_cail_param_loader.sv
// Directed-plus-random bench for cail_param_loader against an EEPROM array model.
module tb_cail_param_loader;

    localparam int NENT    = 48;
    localparam int K_NONE  = 0;
    localparam int K_NACK  = 1;
    localparam int K_SHORT = 2;
    localparam int K_EXTRA = 3;
    localparam int K_STALL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0;
    logic r_valid = 1'b0, wr_done = 1'b0, ack = 1'b0;
    logic [7:0] rd_data = '0;

    logic busy_a, done_a, error_a, busy_b, done_b, error_b;
    logic [3:0] err_ch_a, err_ch_b;
    logic [1:0] err_type_a, err_type_b;

    cail_param_loader_if if_a ();
    cail_param_loader_if if_b ();

    assign if_a.iic_r_valid = r_valid;
    assign if_a.iic_rd_data = rd_data;
    assign if_a.iic_wr_done = wr_done;
    assign if_a.iic_ack     = ack;
    assign if_b.iic_r_valid = r_valid;
    assign if_b.iic_rd_data = rd_data;
    assign if_b.iic_wr_done = wr_done;
    assign if_b.iic_ack     = ack;

    cail_param_loader u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .error(error_a), .err_ch(err_ch_a), .err_type(err_type_a), .bus(if_a)
    );

    cail_param_loader #(.TIMEOUT(24'd100), .BASE_ADDR(16'hFFF8)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .error(error_b), .err_ch(err_ch_b), .err_type(err_type_b), .bus(if_b)
    );

    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        o_rreq, o_wr, o_done, o_busy, o_err;
    logic [15:0] o_addr;
    logic [3:0]  o_ch, o_ech;
    logic [1:0]  o_type, o_etype;
    logic [31:0] o_data;

    always_comb begin
        o_rreq = if_a.iic_r_req;    o_wr = if_a.param_wr_req; o_done = done_a;
        o_busy = busy_a;            o_err = error_a;          o_addr = if_a.iic_reg_addr;
        o_ch = if_a.param_ch;       o_type = if_a.param_type; o_data = if_a.param_data;
        o_ech = err_ch_a;           o_etype = err_type_a;
        if (sel) begin
            o_rreq = if_b.iic_r_req;    o_wr = if_b.param_wr_req; o_done = done_b;
            o_busy = busy_b;            o_err = error_b;          o_addr = if_b.iic_reg_addr;
            o_ch = if_b.param_ch;       o_type = if_b.param_type; o_data = if_b.param_data;
            o_ech = err_ch_b;           o_etype = err_type_b;
        end
    end

    logic [7:0]  mem [65536];
    logic [37:0] wlog [$];
    logic [15:0] alog [$];
    int done_cnt = 0;
    int rreq_cnt = 0;
    int n_checks = 0;
    int n_pass   = 0;

    always @(negedge clk) begin
        if (o_wr)   wlog.push_back({o_ch, o_type, o_data});
        if (o_done) done_cnt++;
        if (o_rreq) rreq_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_addr(input bit inst_b, input int e);
        logic [15:0] base;
        base = inst_b ? 16'hFFF8 : 16'h0000;
        return base + 16'(4 * e);
    endfunction

    function automatic logic [37:0] exp_wr(input bit inst_b, input int e);
        logic [15:0] a;
        logic [3:0]  c;
        logic [1:0]  t;
        a = exp_addr(inst_b, e);
        c = 4'(e / 3);
        t = 2'(e % 3);
        return {c, t, mem[a], mem[a + 16'd1], mem[a + 16'd2], mem[a + 16'd3]};
    endfunction

    task automatic wait_rreq(output bit found);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (o_rreq) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic serve(input logic [15:0] a, input int nb, input bit same, input logic ackv);
        logic [15:0] idx;
        tick;
        for (int i = 0; i < nb; i++) begin
            repeat ($urandom_range(0, 2)) tick;
            idx     = a + 16'(i);
            r_valid = 1'b1;
            rd_data = (i < 4) ? mem[idx] : 8'hEE;
            if (same && i == nb - 1) begin
                wr_done = 1'b1;
                ack     = ackv;
            end
            tick;
            r_valid = 1'b0;
            wr_done = 1'b0;
        end
        if (!same) begin
            wr_done = 1'b1;
            ack     = ackv;
            tick;
            wr_done = 1'b0;
        end
        ack = 1'b0;
    endtask

    task automatic run_load(input bit inst_b, input int kind, input int kidx);
        bit          found;
        bit          same;
        int          nb;
        logic        ackv;
        logic [15:0] a;
        sel = inst_b;
        wlog.delete();
        alog.delete();
        done_cnt = 0;
        if (inst_b) start_b = 1'b1;
        else        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        start_b = 1'b0;
        @(negedge clk);
        check("busy_after_start", o_busy, 1);
        check("error_cleared_by_start", o_err, 0);
        for (int e = 0; e < NENT; e++) begin
            wait_rreq(found);
            check("rreq_seen", found, 1);
            if (!found) return;
            a = exp_addr(inst_b, e);
            alog.push_back(o_addr);
            check("reg_addr", o_addr, a);
            if (kind == K_STALL && e == kidx) return;
            nb   = (kind == K_SHORT && e == kidx) ? 3 : (kind == K_EXTRA && e == kidx) ? 5 : 4;
            ackv = !(kind == K_NACK && e == kidx);
            same = (e == 0) || ($urandom_range(0, 1) == 1);
            if (kind == K_EXTRA && e == kidx) same = 1'b0;
            serve(a, nb, same, ackv);
            if ((kind == K_NACK || kind == K_SHORT) && e == kidx) break;
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic compare_writes(input bit inst_b, input int n);
        check("write_count", wlog.size(), n);
        for (int i = 0; i < n && i < wlog.size(); i++)
            check("write_entry", wlog[i], exp_wr(inst_b, i));
    endtask

    initial begin
        int k;

        // Reset state
        repeat (3) tick;
        @(negedge clk);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_error", o_err, 0);
        check("rst_rreq", o_rreq, 0);
        check("rst_wr", o_wr, 0);
        check("rst_addr", o_addr, 0);
        check("rst_data", o_data, 0);
        check("rst_ch_type", {o_ch, o_type, o_ech, o_etype}, 0);
        check("const_dev_id", if_a.iic_device_id, 8'hA0);
        check("const_addr_mode", if_a.iic_addr_mode, 1);
        check("const_r_num", if_a.iic_r_num, 6'd4);
        rst = 1'b0;
        tick;

        // Full load, byte n = n[7:0]
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i);
        run_load(0, K_NONE, 0);
        compare_writes(0, NENT);
        check("addr_entry_2_1", alog[7], 16'h001C);
        check("data_entry_2_1", wlog[7][31:0], 32'h1C1D1E1F);
        check("full_done_once", done_cnt, 1);
        check("full_busy_low", o_busy, 0);
        check("full_error_low", o_err, 0);

        // NACK on (0,2)
        run_load(0, K_NACK, 2);
        compare_writes(0, 2);
        check("nack_error", o_err, 1);
        check("nack_err_idx", {o_ech, o_etype}, {4'd0, 2'd2});
        check("nack_no_done", done_cnt, 0);
        check("nack_busy_low", o_busy, 0);

        // Short read on (5,0)
        run_load(0, K_SHORT, 15);
        compare_writes(0, 15);
        check("short_error", o_err, 1);
        check("short_err_idx", {o_ech, o_etype}, {4'd5, 2'd0});
        check("short_no_done", done_cnt, 0);

        // Clean rerun on random contents, 4th byte 5A on (0,0), 5th byte on (2,1)
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[3] = 8'h5A;
        run_load(0, K_EXTRA, 7);
        compare_writes(0, NENT);
        check("same_cycle_low_byte", wlog[0][7:0], 8'h5A);
        check("rerun_done_once", done_cnt, 1);
        check("rerun_error_low", o_err, 0);

        // Reset during COLLECT of (3,1)
        run_load(0, K_STALL, 10);
        tick;
        r_valid = 1'b1; rd_data = 8'h11; tick;
        r_valid = 1'b1; rd_data = 8'h22; tick;
        r_valid = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_flags", {o_busy, o_done, o_err, o_rreq, o_wr}, 0);
        check("mid_rst_addr", o_addr, 0);
        check("mid_rst_data", o_data, 0);
        check("mid_rst_idx", {o_ch, o_type, o_ech, o_etype}, 0);
        rreq_cnt = 0;
        tick;
        r_valid = 1'b1; rd_data = 8'h33; tick;
        r_valid = 1'b1; rd_data = 8'h44; wr_done = 1'b1; ack = 1'b1; tick;
        r_valid = 1'b0; wr_done = 1'b0; ack = 1'b0;
        repeat (10) @(negedge clk);
        check("late_no_write", wlog.size(), 10);
        check("late_no_rreq", rreq_cnt, 0);

        // Timeout with TIMEOUT=100
        run_load(1, K_STALL, 0);
        k = 0;
        while (!o_err && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("timeout_cycles", k, 100);
        repeat (3) @(negedge clk);
        check("timeout_error_sticky", o_err, 1);
        check("timeout_err_idx", {o_ech, o_etype}, 0);
        check("timeout_no_write", wlog.size(), 0);

        // Address wrap with BASE_ADDR=FFF8
        run_load(1, K_STALL, 2);
        check("wrap_addr_0_2", alog[2], 16'h0000);
        compare_writes(1, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cail_param_loader.md
Name: cail_param_loader

Overview:
- Boot-time loader that pulls calibration parameters out of the I2C EEPROM and writes them into the calibration parameter store.
- Walks every (channel, type) entry in order. Per entry: one 4-byte EEPROM read through the iic_ctrl read port, assemble the 32-bit word MSB first, then one write into the store.
- Sits between iic_ctrl (initiator side) and the parameter store's write port. Triggered once after power-up or on a host reload command.

Parameters:
- NUM_CH, 16: channels loaded; 1..16.
- NUM_TYPE, 3: parameter types per channel; 1..4.
- DEVICE_ID, 8'hA0: EEPROM device address driven to iic_ctrl.
- BASE_ADDR, 16'h0000: EEPROM byte address of entry (0,0).
- TIMEOUT, 24'd5000000: max cycles allowed from read request to iic_wr_done.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle load request; ignored while busy=1.
- busy  out  1  high from the cycle after accepted start until done/error.
- done  out  1  one-cycle pulse: all entries written.
- error  out  1  sticky fail flag; cleared by next accepted start or rst.
- err_ch  out  4  channel of the failing entry; valid while error=1.
- err_type  out  2  type of the failing entry; valid while error=1.
- iic_r_req  out  1  one-cycle read request to iic_ctrl.
- iic_device_id  out  8  constant DEVICE_ID.
- iic_reg_addr  out  16  EEPROM byte address; held stable while busy.
- iic_addr_mode  out  1  constant 1 (16-bit address).
- iic_r_num  out  6  constant 6'd4.
- iic_r_valid  in  1  one-cycle strobe per received byte.
- iic_rd_data  in  8  received byte; valid with iic_r_valid.
- iic_wr_done  in  1  one-cycle pulse: transaction finished.
- iic_ack  in  1  sampled with iic_wr_done; 0 = device did not acknowledge.
- param_wr_req  out  1  one-cycle write strobe to the parameter store.
- param_ch  out  4  channel index.
- param_type  out  2  type index.
- param_data  out  32  assembled parameter, first EEPROM byte in [31:24].

Behaviour:
- Reset:
  - All outputs 0 except constants (iic_device_id, iic_addr_mode, iic_r_num).
  - FSM to IDLE; index counters, byte counter and timeout counter cleared.
  - rst mid-load aborts immediately. No param_wr_req after rst; any late iic strobes are ignored.
- Entry order: type inner loop, channel outer loop, i.e. (0,0),(0,1),...,(0,NUM_TYPE-1),(1,0),...
- Address: iic_reg_addr = BASE_ADDR + 4*(ch*NUM_TYPE + type), modulo 2^16 (wrap permitted).
- FSM states:
  - IDLE: start=1 -> REQ. On that transition: ch=0, type=0, clear error/err_ch/err_type.
  - REQ: iic_r_req=1 for exactly this cycle; byte_cnt=0, shift reg=0, timeout=0 -> COLLECT.
  - COLLECT:
    - Each iic_r_valid with byte_cnt<4: shift rd_data in from LSB (word = {word[23:0], rd_data}), byte_cnt++.
    - r_valid with byte_cnt=4: ignored.
    - On iic_wr_done (r_valid in the same cycle is counted first): iic_ack=1 and byte_cnt==4 -> WRITE; otherwise -> ERR.
    - timeout reaching TIMEOUT-1 without wr_done -> ERR.
  - WRITE: param_wr_req=1 for one cycle with param_ch/param_type/param_data valid in the same cycle. Then last entry -> DONE; else advance index -> REQ.
  - DONE: done=1 for one cycle -> IDLE.
  - ERR: error=1 (sticky); err_ch/err_type latched from the current index -> IDLE. No further reads or writes.
- Registered outputs; param_ch/param_type/param_data hold their last values between strobes.
- Min per-entry latency from iic_wr_done to param_wr_req: 1 cycle.
- busy=1 in REQ, COLLECT, WRITE, ERR; 0 in IDLE and DONE.
- start during busy: dropped, not queued.
- An entry already written before an error stays written; no rollback.

Decomposition:
- Shared package cail_pkg:
  - FSM state encoding.
  - EEPROM_BYTES_PER_PARAM=4.
  - Default DEVICE_ID.
  - Index widths CH_W=4, TYPE_W=2, also used by cail_param_control.
- One natural sub-module: cail_byte_assembler (byte counter plus 32-bit MSB-first shift register, with clear, count and full outputs). All else inline.

Test Plan:
- Full load, defaults, EEPROM model returning byte n = n[7:0]: 48 param_wr_req pulses in type-then-channel order. Entry (2,1) has reg_addr 16'h001C and data 32'h1C1D1E1F. done pulses once; busy falls; error=0.
- NACK on entry (0,2), iic_ack=0 at wr_done: error=1, err_ch=0, err_type=2; exactly 2 writes issued; no done.
- Short read, only 3 r_valid before wr_done on (5,0): ERR with err_ch=5, err_type=0; no write for (5,0). Then a new start clears error and a clean rerun yields 48 writes.
- Timeout with TIMEOUT=100 and model never raising wr_done: ERR entered exactly 100 cycles after iic_r_req; error=1.
- Same-cycle r_valid and wr_done on the 4th byte 8'h5A: write occurs, param_data[7:0]=8'h5A. A 5th r_valid is ignored.
- rst asserted during COLLECT of entry (3,1): next cycle all outputs 0; late wr_done produces no param_wr_req. Start plus BASE_ADDR=16'hFFF8: entry (0,2) address wraps to 16'h0000.
